// File: rtl/pipe_pkg.sv
// Shared types for the elastic pipeline stage: occupancy states, entry count
// and the depth limit of the two-entry skid configuration.
package pipe_pkg;

  localparam int PIPE_MAX_ENTRIES = 2;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_HALF  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  typedef enum logic [1:0] {
    EMPTY = ST_EMPTY,
    HALF  = ST_HALF,
    FULL  = ST_FULL
  } pipe_state_t;

  typedef logic [1:0] pipe_count_t;

endpackage

// File: rtl/pipe_data_reg.sv
// Payload holding register with synchronous reset, synchronous clear and load
// enable; reset and clear both return it to RESET_VALUE.
module pipe_data_reg #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear) begin
      o_q <= RESET_VALUE;
    end else if (i_enable) begin
      o_q <= i_d;
    end
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready pipeline register. Define PIPE_SKID_EN for the
// two-entry skid version with registered o_ready; otherwise single entry.
//
//   state | meaning
//   EMPTY | nothing held, o_valid low
//   HALF  | main entry holds the head payload
//   FULL  | main holds head, skid holds the next payload, o_ready low
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output pipe_count_t      o_count
);

  pipe_state_t      state_q;
  pipe_state_t      state_d;
  logic             accept;
  logic             consume;
  logic             main_en;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] main_q;
`ifdef PIPE_SKID_EN
  logic             skid_en;
  logic [WIDTH-1:0] skid_q;
`endif

  assign accept  = i_valid && o_ready;
  assign consume = o_valid && i_ready;
  assign o_valid = (state_q != EMPTY);
  assign o_data  = o_valid ? main_q : RESET_VALUE;

`ifdef PIPE_SKID_EN
  // o_ready comes only from registered state, cutting the i_ready path.
  assign o_ready = (state_q != FULL);
  assign o_count = (state_q == FULL) ? pipe_count_t'(2) :
                   (state_q == HALF) ? pipe_count_t'(1) : pipe_count_t'(0);
`else
  assign o_ready = !o_valid || i_ready;
  assign o_count = {1'b0, o_valid};
`endif

  always_comb begin
    state_d = state_q;
    main_en = 1'b0;
    main_d  = i_data;
`ifdef PIPE_SKID_EN
    skid_en = 1'b0;
`endif
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = HALF;
          main_en = 1'b1;
        end
      end
      HALF: begin
        if (accept && consume) begin
          main_en = 1'b1;
`ifdef PIPE_SKID_EN
        end else if (accept) begin
          state_d = FULL;
          skid_en = 1'b1;
`endif
        end else if (consume) begin
          state_d = EMPTY;
        end
      end
`ifdef PIPE_SKID_EN
      FULL: begin
        if (consume) begin
          state_d = HALF;
          main_en = 1'b1;
          main_d  = skid_q;
        end
      end
`endif
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset || i_flush) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  pipe_data_reg #(
    .WIDTH      (WIDTH),
    .RESET_VALUE(RESET_VALUE)
  ) u_main (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_enable(main_en),
    .i_clear (i_flush),
    .i_d     (main_d),
    .o_q     (main_q)
  );

`ifdef PIPE_SKID_EN
  pipe_data_reg #(
    .WIDTH      (WIDTH),
    .RESET_VALUE(RESET_VALUE)
  ) u_skid (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_enable(skid_en),
    .i_clear (i_flush),
    .i_d     (i_data),
    .o_q     (skid_q)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Self-checking bench for pipe_stage_elastic: directed scenarios plus random
// traffic, compared against a FIFO-queue reference model.
module tb_pipe_stage_elastic;
  import pipe_pkg::*;

  localparam int               W  = 16;
  localparam logic [W-1:0]     RV = 16'hA5A5;
`ifdef PIPE_SKID_EN
  localparam int               CAP = PIPE_MAX_ENTRIES;
`else
  localparam int               CAP = 1;
`endif

  logic         i_clock = 1'b0;
  logic         i_reset = 1'b1;
  logic         i_flush = 1'b0;
  logic         i_valid = 1'b0;
  logic [W-1:0] i_data  = '0;
  logic         i_ready = 1'b0;
  logic         o_ready;
  logic         o_valid;
  logic [W-1:0] o_data;
  pipe_count_t  o_count;

  int           n_checks = 0;
  int           n_pass   = 0;
  bit           armed    = 1'b0;
  logic [W-1:0] model_q[$];

  always #5 i_clock = ~i_clock;

  pipe_stage_elastic #(.WIDTH(W), .RESET_VALUE(RV)) dut (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .i_flush(i_flush),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_data (i_data),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_data (o_data),
    .o_count(o_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Drive one cycle of inputs, compare outputs against the queue model, then
  // advance the model by what the rising edge will do.
  task automatic step(input bit rst, input bit fl, input bit v,
                      input logic [W-1:0] d, input bit rdy);
    bit           exp_valid, exp_ready, acc, con;
    logic [W-1:0] exp_data;
    @(negedge i_clock);
    i_reset = rst; i_flush = fl; i_valid = v; i_data = d; i_ready = rdy;
    #1;
    exp_valid = (model_q.size() != 0);
    exp_data  = exp_valid ? model_q[0] : RV;
    exp_ready = (CAP > 1) ? (model_q.size() < CAP) : (!exp_valid || rdy);
    if (armed) begin
      check("o_valid", 32'(o_valid), 32'(exp_valid));
      check("o_ready", 32'(o_ready), 32'(exp_ready));
      check("o_data",  32'(o_data),  32'(exp_data));
      check("o_count", 32'(o_count), 32'(model_q.size()));
    end
    acc = v && exp_ready;
    con = exp_valid && rdy;
    if (rst || fl) begin
      model_q.delete();
    end else begin
      if (con) void'(model_q.pop_front());
      if (acc) model_q.push_back(d);
    end
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int k = 0; k < n; k++) step(0, 0, 0, 16'h0, rdy);
  endtask

  initial begin
    step(1, 0, 0, 16'h0, 0);
    step(1, 0, 0, 16'h0, 0);
    model_q.delete();
    armed = 1'b1;
    step(0, 0, 0, 16'h0, 0);

    // reset mid-traffic after filling with 0xA, 0xB
    step(0, 0, 1, 16'h000A, 0);
    step(0, 0, 1, 16'h000B, 0);
    step(1, 0, 1, 16'h000C, 0);
    idle(2, 0);

    // streaming with downstream always ready
    for (int k = 1; k <= 8; k++) step(0, 0, 1, W'(k), 1);
    idle(2, 1);

    // back-pressure into the skid entry, then drain in order
    step(0, 0, 1, 16'h0011, 0);
    step(0, 0, 1, 16'h0022, 0);
    step(0, 0, 1, 16'h0033, 0);
    step(0, 0, 1, 16'h0033, 1);
    step(0, 0, 1, 16'h0033, 1);
    idle(3, 1);

    // flush while full, with a payload offered in the same cycle
    step(0, 0, 1, 16'h0001, 0);
    step(0, 0, 1, 16'h0002, 0);
    step(0, 1, 1, 16'h0044, 0);
    idle(2, 1);

    // flush and reset together
    step(0, 0, 1, 16'h0055, 0);
    step(0, 0, 1, 16'h0066, 0);
    step(1, 1, 1, 16'h0077, 1);
    idle(2, 1);

    // single-entry style: held entry with i_ready low, then pass-through
    step(0, 0, 1, 16'h0101, 0);
    step(0, 0, 1, 16'h0202, 0);
    step(0, 0, 1, 16'h0303, 1);
    step(0, 0, 1, 16'h0404, 1);
    idle(3, 1);

    for (int k = 0; k < 3000; k++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) == 0),
           ($urandom_range(0, 3) != 0), W'($urandom), ($urandom_range(0, 2) != 0));
    end
    idle(4, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
